// File: rtl/shift_unit_seq.sv
// shift_unit_seq: sequential shift/rotate unit for the multicycle datapath.
// The source and the amount are selected and latched when start is accepted.
// The unit then shifts STEP bits per cycle until the amount is used up.
// It raises done for one cycle when the result is valid.
//
// Build option: define SHIFT_ROTATE_EN to enable rol (op 100) and ror (op 101).
// When SHIFT_ROTATE_EN is undefined, those two ops behave as a load.
//
// Handshake: start is sampled only while IDLE and is ignored while busy is high.
// busy is high in SHIFT and DONE. done is high for exactly the one DONE cycle.
// result holds its value from done until the next accepted start.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 1,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       shift_op,
  input  logic [1:0]       amt_sel,
  input  logic [1:0]       src_sel,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [IMM_W-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The amount is one bit wider than shamt so the constant IMM_W is never truncated.
  localparam logic [SHW:0] STEP_A = (SHW+1)'(STEP);
  localparam logic [SHW:0] IMM_A  = (SHW+1)'(IMM_W);
`ifdef SHIFT_ROTATE_EN
  localparam logic [SHW:0] WIDTH_A = (SHW+1)'(WIDTH);
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHW:0]       rem_q, rem_d;
  logic [2:0]         op_q, op_d;

  logic [WIDTH-1:0]   src_mux;
  logic [SHW:0]       amt_mux;
  logic [SHW:0]       step_n;
  logic [WIDTH-1:0]   shifted;
  logic               accept;

  // Return 1 for ops that move bits; every other encoding is a plain load.
  function automatic logic op_is_shift(input logic [2:0] op);
    case (op)
      3'b001, 3'b010, 3'b011: op_is_shift = 1'b1;
`ifdef SHIFT_ROTATE_EN
      3'b100, 3'b101:         op_is_shift = 1'b1;
`endif
      default:                op_is_shift = 1'b0;
    endcase
  endfunction

  // Select the operand and the amount that are latched on the accept edge.
  always_comb begin
    src_mux = a_in;
    case (src_sel)
      2'b00:   src_mux = a_in;
      2'b01:   src_mux = b_in;
      2'b10:   src_mux = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
      default: src_mux = {{(WIDTH-IMM_W){1'b0}}, imm};
    endcase
    amt_mux = '0;
    case (amt_sel)
      2'b00:   amt_mux = {1'b0, shamt};
      2'b01:   amt_mux = {1'b0, b_in[SHW-1:0]};
      2'b10:   amt_mux = IMM_A;
      default: amt_mux = '0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && start;

  // One shift step: move by min(STEP, remaining) bits in the latched direction.
  always_comb begin
    step_n  = (rem_q < STEP_A) ? rem_q : STEP_A;
    shifted = result_q;
    case (op_q)
      3'b001:  shifted = result_q << step_n;
      3'b010:  shifted = result_q >> step_n;
      3'b011:  shifted = $signed(result_q) >>> step_n;
`ifdef SHIFT_ROTATE_EN
      3'b100:  shifted = (result_q << step_n) | (result_q >> (WIDTH_A - step_n));
      3'b101:  shifted = (result_q >> step_n) | (result_q << (WIDTH_A - step_n));
`endif
      default: shifted = result_q;
    endcase
  end

  // Datapath next-state: latch on accept, step while shifting, otherwise hold.
  always_comb begin
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    if (accept) begin
      result_d = src_mux;
      rem_d    = amt_mux;
      op_d     = shift_op;
    end else if (state_q == S_SHIFT) begin
      result_d = shifted;
      rem_d    = rem_q - step_n;
    end
  end

  // State and datapath registers; reset clears everything and aborts an operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
    end
  end

  // Next-state logic: loads and zero amounts skip SHIFT; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op_is_shift(shift_op) || (amt_mux == '0)) state_d = S_DONE;
          else                                           state_d = S_SHIFT;
        end
      end
      S_SHIFT: if (rem_q == step_n) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy        = (state_q == S_SHIFT) || (state_q == S_DONE);
    done        = (state_q == S_DONE);
    result      = result_q;
    dbg_state_o = state_q;
  end

endmodule
